// File: rtl/ram_arbiter.sv
// ram_arbiter
// Sits in front of a single-clock RAM with a registered read port. After reset
// it walks every address once, writing zero. It then shares the RAM between
// requesters A and B, granting at most one access per cycle.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata   requester A request (held until a_gnt)
//   a_gnt              A granted this cycle (combinational)
//   a_rvalid/a_rdata   A read return, one cycle after the read grant
//   b_*                same set for requester B
//   init_done          high once the clear pass has finished
//   ram_wr_*           RAM write port
//   ram_rd_*           RAM read port (ram_rd_data valid the cycle after a read)
//
// Configuration macro:
//   RAM_ARB_FIXED_PRIO_EN  defined: A always wins a collision, so there is no
//                          round-robin pointer. Undefined: round-robin.
module ram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              init_done,
  output logic              ram_wr_enb,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_rd_enb,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                init_done_q, init_done_d;
  logic                rd_pend_q, rd_pend_d;    // a read return is due this cycle
  logic                rd_owner_q, rd_owner_d;  // 0 = A, 1 = B
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;

  logic                gnt_a, gnt_b;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;
  logic                wr_enb, rd_enb;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;

`ifndef RAM_ARB_FIXED_PRIO_EN
  logic                rr_ptr_q, rr_ptr_d;      // 0 = A wins next collision
`endif

  // Arbitration: only meaningful in RUN; INIT holds requests off.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (state_q == RUN) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      gnt_a = a_req;
      gnt_b = b_req & ~a_req;
`else
      gnt_a = a_req & (~b_req | ~rr_ptr_q);
      gnt_b = b_req & (~a_req |  rr_ptr_q);
`endif
    end
  end

  // Winner's request fields.
  always_comb begin
    win_we    = gnt_b ? b_we    : a_we;
    win_addr  = gnt_b ? b_addr  : a_addr;
    win_wdata = gnt_b ? b_wdata : a_wdata;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    wr_enb      = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    rd_enb      = 1'b0;
    case (state_q)
      INIT: begin
        wr_enb  = 1'b1;
        wr_addr = cnt_q;
        // Stop at the last address instead of letting the counter wrap.
        if (cnt_q == LAST_ADDR) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (gnt_a | gnt_b) begin
          wr_enb  = win_we;
          wr_addr = win_addr;
          wr_data = win_wdata;
          rd_enb  = ~win_we;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Read return tracking; rdata of the non-owner keeps its last value.
  always_comb begin
    rd_pend_d  = rd_enb;
    rd_owner_d = gnt_b;
    a_rdata_d  = a_rvalid ? ram_rd_data : a_rdata_q;
    b_rdata_d  = b_rvalid ? ram_rd_data : b_rdata_q;
  end

`ifndef RAM_ARB_FIXED_PRIO_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_a)      rr_ptr_d = 1'b1;
    else if (gnt_b) rr_ptr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_ptr_q <= 1'b0;
    else      rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_owner_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rd_pend_q   <= rd_pend_d;
      rd_owner_q  <= rd_owner_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  // Combinational outputs are gated by rst so they drop the moment reset
  // asserts, even though state_q only changes on the reset edge.
  assign a_gnt       = rst & gnt_a;
  assign b_gnt       = rst & gnt_b;
  assign ram_wr_enb  = rst & wr_enb;
  assign ram_rd_enb  = rst & rd_enb;
  assign ram_wr_addr = rst ? wr_addr : '0;
  assign ram_wr_data = rst ? wr_data : '0;
  assign ram_rd_addr = (rst & rd_enb) ? win_addr : '0;

  assign a_rvalid  = rd_pend_q & ~rd_owner_q;
  assign b_rvalid  = rd_pend_q &  rd_owner_q;
  assign a_rdata   = a_rvalid ? ram_rd_data : a_rdata_q;
  assign b_rdata   = b_rvalid ? ram_rd_data : b_rdata_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a 16x8 RAM model behind it.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, init_done;
  logic [7:0] a_rdata, b_rdata;
  logic       ram_wr_enb, ram_rd_enb;
  logic [3:0] ram_wr_addr, ram_rd_addr;
  logic [7:0] ram_wr_data, ram_rd_data;

`ifdef RAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .init_done(init_done),
    .ram_wr_enb(ram_wr_enb), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_enb(ram_rd_enb), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  // RAM model: synchronous write, registered read. Starts with non-zero
  // contents so the clear pass is observable.
  logic [7:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 8'hA5;
  initial ram_rd_data = 8'h00;
  always @(posedge clk) begin
    if (ram_wr_enb) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_enb) ram_rd_data <= mem[ram_rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  initial begin
    bit exp_a, prev_a;
    rst = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd0; a_wdata = 8'd0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 4'd0; b_wdata = 8'd0;

    // Held in reset: everything quiet even with a request pending.
    settle(); #1;
    chk("rst_init_done", init_done, 0);
    chk("rst_wr_enb", ram_wr_enb, 0);
    chk("rst_rd_enb", ram_rd_enb, 0);
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    settle();
    a_req = 1'b0;
    rst = 1'b1;

    // Clear pass; B posts a read of addr 2 at cycle 4 and must be held off.
    for (int i = 0; i < 16; i++) begin
      if (i == 4) begin b_req = 1'b1; b_we = 1'b0; b_addr = 4'd2; end
      #1;
      chk($sformatf("init_wr_enb_%0d", i), ram_wr_enb, 1);
      chk($sformatf("init_wr_addr_%0d", i), ram_wr_addr, i);
      chk($sformatf("init_wr_data_%0d", i), ram_wr_data, 0);
      chk($sformatf("init_done_lo_%0d", i), init_done, 0);
      chk($sformatf("init_b_gnt_%0d", i), b_gnt, 0);
      settle();
    end
    #1;
    chk("init_done_hi", init_done, 1);
    chk("run_wr_enb_idle", ram_wr_enb, 0);
    chk("b_gnt_first_run", b_gnt, 1);
    chk("b_rd_enb", ram_rd_enb, 1);
    chk("b_rd_addr", ram_rd_addr, 2);

    // B's return, then A sweeps reads of 0..15 back to back.
    settle();
    b_req = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd0;
    #1;
    chk("b_rvalid_init_rd", b_rvalid, 1);
    chk("b_rdata_init_rd", b_rdata, 0);
    chk("a_rvalid_idle", a_rvalid, 0);
    chk("a_gnt_sweep_0", a_gnt, 1);
    for (int k = 1; k < 16; k++) begin
      settle();
      a_addr = 4'(k);
      #1;
      chk($sformatf("sweep_gnt_%0d", k), a_gnt, 1);
      chk($sformatf("sweep_rvalid_%0d", k - 1), a_rvalid, 1);
      chk($sformatf("sweep_rdata_%0d", k - 1), a_rdata, 0);
    end
    settle();
    a_req = 1'b0;
    #1;
    chk("sweep_rvalid_15", a_rvalid, 1);
    chk("sweep_rdata_15", a_rdata, 0);
    chk("sweep_b_rvalid", b_rvalid, 0);

    // A writes 10 <= 23, then reads it back.
    settle();
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd10; a_wdata = 8'd23;
    #1;
    chk("aw_gnt", a_gnt, 1);
    chk("aw_wr_enb", ram_wr_enb, 1);
    chk("aw_wr_addr", ram_wr_addr, 10);
    chk("aw_wr_data", ram_wr_data, 23);
    chk("aw_rd_enb", ram_rd_enb, 0);
    settle();
    a_we = 1'b0;
    #1;
    chk("ar_gnt", a_gnt, 1);
    chk("ar_rd_enb", ram_rd_enb, 1);
    chk("ar_rd_addr", ram_rd_addr, 10);
    chk("aw_no_rvalid", a_rvalid, 0);
    settle();
    a_req = 1'b0;
    #1;
    chk("ar_rvalid", a_rvalid, 1);
    chk("ar_rdata", a_rdata, 23);
    chk("ar_b_rvalid", b_rvalid, 0);
    settle(); #1;
    chk("ar_rvalid_pulse", a_rvalid, 0);
    chk("ar_rdata_hold", a_rdata, 23);

    // Seed addr 3 (by A) and addr 5 (by B); leaves the pointer on A.
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd3; a_wdata = 8'h33;
    #1; chk("seed_a_gnt", a_gnt, 1);
    settle();
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 4'd5; b_wdata = 8'h55;
    #1; chk("seed_b_gnt", b_gnt, 1);
    settle();

    // Contention: A reads 3, B reads 5, both held for 8 cycles.
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd3;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd5;
    prev_a = 1'b0;
    for (int c = 0; c < 8; c++) begin
      exp_a = FIXED ? 1'b1 : (c % 2 == 0);
      #1;
      chk($sformatf("cont_a_gnt_%0d", c), a_gnt, exp_a);
      chk($sformatf("cont_b_gnt_%0d", c), b_gnt, !exp_a);
      chk($sformatf("cont_rd_addr_%0d", c), ram_rd_addr, exp_a ? 3 : 5);
      if (c > 0) begin
        chk($sformatf("cont_a_rvalid_%0d", c), a_rvalid, prev_a);
        chk($sformatf("cont_b_rvalid_%0d", c), b_rvalid, !prev_a);
        if (prev_a) chk($sformatf("cont_a_rdata_%0d", c), a_rdata, 8'h33);
        else        chk($sformatf("cont_b_rdata_%0d", c), b_rdata, 8'h55);
      end
      prev_a = exp_a;
      settle();
    end
    // A drops; B is granted on this cycle.
    a_req = 1'b0;
    #1;
    chk("post_b_gnt", b_gnt, 1);
    chk("post_a_rvalid", a_rvalid, FIXED);
    chk("post_b_rvalid", b_rvalid, !FIXED);
    settle();

    // A write 7 <= 0x77 against B read 7: A wins, B waits and sees new data.
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd7; a_wdata = 8'h77;
    b_addr = 4'd7;
    #1;
    chk("coll_b_rvalid", b_rvalid, 1);
    chk("coll_b_rdata", b_rdata, 8'h55);
    chk("coll_a_gnt", a_gnt, 1);
    chk("coll_b_gnt", b_gnt, 0);
    chk("coll_rd_enb", ram_rd_enb, 0);
    settle();
    a_req = 1'b0;
    #1;
    chk("coll_b_gnt2", b_gnt, 1);
    chk("coll_rd_addr", ram_rd_addr, 7);
    settle();
    b_req = 1'b0;
    #1;
    chk("coll_b_rvalid2", b_rvalid, 1);
    chk("coll_b_rdata2", b_rdata, 8'h77);
    settle();

    // Reset lands while A's read is granted but before its edge.
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd10;
    #1; chk("mid_a_gnt", a_gnt, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_a_gnt_off", a_gnt, 0);
    chk("mid_rd_enb", ram_rd_enb, 0);
    chk("mid_wr_enb", ram_wr_enb, 0);
    chk("mid_b_rdata", b_rdata, 0);
    settle(); #1;
    chk("mid_a_rvalid", a_rvalid, 0);
    chk("mid_init_done", init_done, 0);
    settle();
    a_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("reinit_wr_enb", ram_wr_enb, 1);
    chk("reinit_addr0", ram_wr_addr, 0);
    settle(); #1;
    chk("reinit_addr1", ram_wr_addr, 1);
    repeat (15) settle();
    #1;
    chk("reinit_done", init_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester access controller for the single-clock 16x8 RAM: it clears every RAM location after reset, then shares the RAM's write and read ports between requester A and requester B with round-robin arbitration. It sits directly in front of the RAM; the RAM ports connect straight through to it, and no requester touches the RAM directly. At most one access is granted per cycle. Read data returns to the granted requester one cycle after the grant.

## Interface
Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM data width.
- DEPTH, 1<<ADDR_W, number of locations cleared at init.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- a_req  in  1  requester A request; held high until a_gnt.
- a_we  in  1  A: 1=write, 0=read; stable while a_req is high.
- a_addr  in  ADDR_W  A address.
- a_wdata  in  DATA_W  A write data.
- a_gnt  out  1  A granted this cycle (combinational).
- a_rvalid  out  1  A read data valid (registered).
- a_rdata  out  DATA_W  A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B.
- init_done  out  1  high once the clear sequence has completed.
- ram_wr_enb  out  1  RAM write enable.
- ram_wr_addr  out  ADDR_W  RAM write address.
- ram_wr_data  out  DATA_W  RAM write data.
- ram_rd_enb  out  1  RAM read enable.
- ram_rd_addr  out  ADDR_W  RAM read address.
- ram_rd_data  in  DATA_W  RAM read data; valid the cycle after a read is sampled.

## Operation
- FSM states: INIT, RUN.
- Reset puts the block in INIT with clear counter=0, init_done=0, rr_ptr=A.
- Reset also clears a_rvalid, b_rvalid, and the read-owner register.
- While rst=0, all outputs are 0. RAM enables and grants are gated by rst.
- INIT:
  - Each cycle drives ram_wr_enb=1, ram_wr_addr=counter, ram_wr_data=0, then increments the counter.
  - After the write at address DEPTH-1, the FSM goes to RUN and init_done goes to 1.
  - No grants are issued in INIT. Requests are held off, not dropped.
- RUN arbitration:
  - Only A requesting: grant A.
  - Only B requesting: grant B.
  - Both requesting: grant the requester selected by rr_ptr.
  - After every grant, rr_ptr points to the other requester.
  - No request: rr_ptr holds.
- Granted write: ram_wr_enb=1 with the winner's addr/wdata for that cycle. Read enable stays 0.
- Granted read: ram_rd_enb=1, ram_rd_addr=winner addr. The owner is registered.
- Read return: on the next cycle, the owner's rvalid=1 and its rdata=ram_rd_data.
  - rdata of the non-owner holds its last value.
  - rvalid is a single-cycle pulse per read.
- RUN is absorbing. Only reset returns the FSM to INIT.

## Timing
- Grant latency: 0 cycles. gnt is asserted in the same cycle as req when eligible, and the requester drops or changes req after the rising edge where gnt=1.
- Read latency: rvalid is asserted exactly 1 cycle after the gnt cycle.
- Back-to-back reads are fully pipelined: one read per cycle, with rvalid trailing by 1 cycle.
- Write completes at the rising edge of the gnt cycle. A read granted in the following cycle returns the new data.
- Init takes DEPTH cycles after rst deasserts; init_done rises on edge DEPTH.
- Address wrap: the clear counter is ADDR_W wide and terminates at DEPTH-1. It does not wrap into a second pass.
- Reset asserted mid-operation: outputs go to 0 immediately (asynchronously). A pending read's rvalid is lost. The clear sequence restarts from address 0.
- Simultaneous A write and B read: only one is granted; the other waits at least 1 cycle.

## Configuration
- RAM_ARB_FIXED_PRIO_EN: when defined, A always wins when both A and B request, and rr_ptr is not implemented.
  - B can be starved; this is acceptable when A is a latency-critical client.
- Undefined (default): round-robin as described above. Each requester is granted within 2 cycles of asserting req while in RUN.

## Test plan
- Reset release, no requests → init_done=0 for 16 cycles with ram_wr_addr stepping 0..15 and ram_wr_data=0; init_done=1 at edge 16. Subsequent reads of addresses 0..15 return 0.
- A writes addr 10 data 23, then A reads addr 10 → a_gnt on both requests; a_rvalid=1 and a_rdata=23 one cycle after the read grant; b_rvalid stays 0.
- A and B both request continuously for 8 cycles (A reads addr 3, B reads addr 5) → grants alternate A,B,A,B…; each rvalid pulses on alternate cycles with the correct data.
- Same A/B contention with RAM_ARB_FIXED_PRIO_EN defined → a_gnt=1 every cycle and b_gnt=0 until a_req drops; B is then granted on the next cycle.
- Request issued during INIT (B read addr 2 at cycle 4) → b_gnt=0 until init_done=1; granted on the first RUN cycle; b_rdata=0.
- rst pulsed low while a read is in flight → a_rvalid=0 and all RAM enables are 0 immediately; the clear sequence restarts at address 0 after release.
